// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour alarm clock core with keypad entry, BCD time/alarm registers and ASCII HH:MM display.
// Optional ALARM_AUTO_OFF_EN silences a sounding alarm after 60 seconds.
module alarm_clock #(
  parameter int CLKS_PER_SEC    = 256,
  parameter int KEY_TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       stopwatch,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [3:0] key,
  output logic       alarm_sound,
  output logic [7:0] ms_hour,
  output logic [7:0] ls_hour,
  output logic [7:0] ms_minute,
  output logic [7:0] ls_minute
);
  localparam int CW = CLKS_PER_SEC > 1 ? $clog2(CLKS_PER_SEC) : 1;
  localparam int TW = $clog2(KEY_TIMEOUT_SEC + 1);

  typedef enum logic [2:0] {
    SHOW_TIME, KEY_ENTRY, KEY_WAIT_RELEASE, SHOW_ALARM, SET_ALARM, SET_TIME
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [5:0]    sec_q, sec_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   tm_q, tm_d, al_q, al_d, buf_q, buf_d, disp_q, disp_d;
  logic          key_prev_q, key_prev_d, tick_q, tick_d, snd_q, snd_d;
  logic          key_valid, accept, one_second, one_minute, auto_off;

  // Time values are {ms_hr, ls_hr, ms_min, ls_min}, one BCD digit each.
  function automatic logic [15:0] incr(input logic [15:0] t);
    logic [3:0] mh, lh, mm, lm;
    {mh, lh, mm, lm} = t;
    if (lm != 4'd9) return {mh, lh, mm, lm + 4'd1};
    if (mm != 4'd5) return {mh, lh, mm + 4'd1, 4'd0};
    if (mh == 4'd2 && lh == 4'd3) return 16'h0000;
    if (lh != 4'd9) return {mh, lh + 4'd1, 8'h00};
    return {mh + 4'd1, 12'h000};
  endfunction

  function automatic logic [15:0] clamp(input logic [15:0] b);
    logic [7:0] h, m;
    h = (b[15:12] > 4'd2 || (b[15:12] == 4'd2 && b[11:8] > 4'd3)) ? 8'h23 : b[15:8];
    m = (b[7:4] > 4'd5) ? 8'h59 : b[7:0];
    return {h, m};
  endfunction

`ifdef ALARM_AUTO_OFF_EN
  logic [5:0] aoff_q, aoff_d;
  always_comb begin
    aoff_d   = snd_q ? aoff_q + 6'(one_second) : 6'd0;
    auto_off = snd_q && one_second && aoff_q == 6'd59;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) aoff_q <= '0;
    else aoff_q <= aoff_d;
`else
  assign auto_off = 1'b0;
`endif

  always_comb begin
    key_valid  = key < 4'd10;
    accept     = key_valid && !key_prev_q;
    one_second = cyc_q == CW'(CLKS_PER_SEC - 1);
    one_minute = one_second && (stopwatch || sec_q == 6'd59);
    key_prev_d = key_valid;
    cyc_d      = one_second ? '0 : cyc_q + CW'(1);
    sec_d      = !one_second ? sec_q : sec_q == 6'd59 ? 6'd0 : sec_q + 6'd1;
    tm_d       = one_minute ? incr(tm_q) : tm_q;
    tick_d     = one_minute;
    to_d       = state_q != KEY_ENTRY ? '0 : to_q + TW'(one_second);
    al_d       = al_q;
    buf_d      = buf_q;
    state_d    = state_q;
    case (state_q)
      SHOW_TIME:
        if (accept) begin
          buf_d   = {buf_q[11:0], key};
          state_d = KEY_WAIT_RELEASE;
        end else if (alarm_button) state_d = SHOW_ALARM;
      KEY_WAIT_RELEASE: if (!key_valid) state_d = KEY_ENTRY;
      KEY_ENTRY:
        if (time_button) state_d = SET_TIME;
        else if (alarm_button) state_d = SET_ALARM;
        else if (accept) begin
          buf_d   = {buf_q[11:0], key};
          state_d = KEY_WAIT_RELEASE;
        end else if (one_second && to_q == TW'(KEY_TIMEOUT_SEC - 1)) begin
          buf_d   = '0;
          state_d = SHOW_TIME;
        end
      SHOW_ALARM: if (!alarm_button) state_d = SHOW_TIME;
      SET_ALARM: begin
        al_d    = clamp(buf_q);
        buf_d   = '0;
        state_d = SHOW_TIME;
      end
      SET_TIME: begin
        // A loaded time must never look like a minute increment to the alarm.
        tm_d    = clamp(buf_q);
        tick_d  = 1'b0;
        cyc_d   = '0;
        sec_d   = '0;
        buf_d   = '0;
        state_d = SHOW_TIME;
      end
      default: state_d = SHOW_TIME;
    endcase
    disp_d = (state_q == KEY_ENTRY || state_q == KEY_WAIT_RELEASE) ? buf_q :
             state_q == SHOW_ALARM ? al_q : tm_q;
    snd_d  = (alarm_button || auto_off) ? 1'b0 : (tick_q && tm_q == al_q) ? 1'b1 : snd_q;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q    <= SHOW_TIME;
      cyc_q      <= '0;
      sec_q      <= '0;
      to_q       <= '0;
      tm_q       <= '0;
      al_q       <= '0;
      buf_q      <= '0;
      disp_q     <= '0;
      key_prev_q <= 1'b0;
      tick_q     <= 1'b0;
      snd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      sec_q      <= sec_d;
      to_q       <= to_d;
      tm_q       <= tm_d;
      al_q       <= al_d;
      buf_q      <= buf_d;
      disp_q     <= disp_d;
      key_prev_q <= key_prev_d;
      tick_q     <= tick_d;
      snd_q      <= snd_d;
    end

  assign alarm_sound = snd_q;
  assign ms_hour     = {4'h3, disp_q[15:12]};
  assign ls_hour     = {4'h3, disp_q[11:8]};
  assign ms_minute   = {4'h3, disp_q[7:4]};
  assign ls_minute   = {4'h3, disp_q[3:0]};
endmodule

// File: tb/tb_alarm_clock.sv
// tb_alarm_clock: directed plus random stimulus against a minutes-of-day reference model.
module tb_alarm_clock;
  localparam int CPS = 256;
  localparam int KTO = 10;
  localparam int IDLE = 0, ENTRY = 1, HELD = 2, VIEW = 3, LOAD_A = 4, LOAD_T = 5;

  logic        clock = 1'b0, reset = 1'b0, stopwatch = 1'b0;
  logic        alarm_button = 1'b0, time_button = 1'b0;
  logic [3:0]  key = 4'd10;
  logic        alarm_sound;
  logic [7:0]  ms_hour, ls_hour, ms_minute, ls_minute;
  logic [31:0] disp;
  int          n_tests = 0, n_fail = 0;

  int          m_cyc, m_sec, m_now, m_alm, m_mode, m_idle;
  int          m_dig[4];
  bit          m_prev, m_tick, m_snd;
  logic [15:0] m_disp;
`ifdef ALARM_AUTO_OFF_EN
  int          m_sndsec;
`endif

  alarm_clock #(.CLKS_PER_SEC(CPS), .KEY_TIMEOUT_SEC(KTO)) dut (
    .clock(clock), .reset(reset), .stopwatch(stopwatch),
    .alarm_button(alarm_button), .time_button(time_button), .key(key),
    .alarm_sound(alarm_sound), .ms_hour(ms_hour), .ls_hour(ls_hour),
    .ms_minute(ms_minute), .ls_minute(ls_minute)
  );

  assign disp = {ms_hour, ls_hour, ms_minute, ls_minute};
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int m);
    return {4'(m / 600), 4'((m / 60) % 10), 4'((m % 60) / 10), 4'(m % 10)};
  endfunction

  function automatic logic [31:0] asc(input logic [15:0] d);
    return {4'h3, d[15:12], 4'h3, d[11:8], 4'h3, d[7:4], 4'h3, d[3:0]};
  endfunction

  function automatic int entered_minutes();
    int h, m;
    h = m_dig[0] * 10 + m_dig[1];
    m = m_dig[2] * 10 + m_dig[3];
    return (h > 23 ? 23 : h) * 60 + (m > 59 ? 59 : m);
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_sec = 0; m_now = 0; m_alm = 0; m_mode = IDLE; m_idle = 0;
    foreach (m_dig[i]) m_dig[i] = 0;
    m_prev = 0; m_tick = 0; m_snd = 0; m_disp = '0;
`ifdef ALARM_AUTO_OFF_EN
    m_sndsec = 0;
`endif
  endtask

  task automatic model_step();
    bit ks, acc, os, om, ab, off, timeout;
    if (!reset) begin
      model_reset();
      return;
    end
    ks  = key < 4'd10;
    acc = ks && !m_prev;
    ab  = alarm_button;
    os  = m_cyc == CPS - 1;
    om  = os && (stopwatch || m_sec == 59);
    m_disp = (m_mode == ENTRY || m_mode == HELD) ?
             {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])} :
             m_mode == VIEW ? bcd(m_alm) : bcd(m_now);
    off = 0;
`ifdef ALARM_AUTO_OFF_EN
    off = m_snd && os && m_sndsec == 59;
    m_sndsec = m_snd ? m_sndsec + int'(os) : 0;
`endif
    if (ab || off) m_snd = 0;
    else if (m_tick && m_now == m_alm) m_snd = 1;
    m_tick  = om;
    m_prev  = ks;
    timeout = os && m_idle == KTO - 1;
    m_idle  = m_mode == ENTRY ? m_idle + int'(os) : 0;
    if (os) m_sec = (m_sec + 1) % 60;
    m_cyc = os ? 0 : m_cyc + 1;
    if (om) m_now = (m_now + 1) % 1440;
    case (m_mode)
      IDLE: if (acc) begin
        m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = int'(key);
        m_mode = HELD;
      end else if (ab) m_mode = VIEW;
      HELD: if (!ks) m_mode = ENTRY;
      ENTRY: if (time_button) m_mode = LOAD_T;
      else if (ab) m_mode = LOAD_A;
      else if (acc) begin
        m_dig[0] = m_dig[1]; m_dig[1] = m_dig[2]; m_dig[2] = m_dig[3]; m_dig[3] = int'(key);
        m_mode = HELD;
      end else if (timeout) begin
        foreach (m_dig[i]) m_dig[i] = 0;
        m_mode = IDLE;
      end
      VIEW: if (!ab) m_mode = IDLE;
      LOAD_A: begin
        m_alm = entered_minutes();
        foreach (m_dig[i]) m_dig[i] = 0;
        m_mode = IDLE;
      end
      LOAD_T: begin
        m_now = entered_minutes();
        foreach (m_dig[i]) m_dig[i] = 0;
        m_cyc = 0; m_sec = 0; m_tick = 0;
        m_mode = IDLE;
      end
      default: m_mode = IDLE;
    endcase
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("disp", disp, asc(m_disp));
    check("snd", 32'(alarm_sound), 32'(m_snd));
  endtask

  task automatic press(input int d, input int hold, input int rel);
    key = 4'(d);
    repeat (hold) tick();
    key = 4'd10;
    repeat (rel) tick();
  endtask

  initial begin
    model_reset();
    stopwatch = 1'b1;
    repeat (5) begin
      tick();
      check("rst_disp", disp, 32'h30303030);
      check("rst_snd", 32'(alarm_sound), 32'd0);
    end
    reset = 1'b1;
    tick();
    press(1, 3, 1); press(1, 3, 1); press(2, 3, 1); press(3, 3, 1);
    time_button = 1'b1; tick(); time_button = 1'b0;
    repeat (3) tick();
    check("set_time", disp, 32'h31313233);
    press(1, 3, 1); press(1, 3, 1); press(3, 3, 1); press(0, 3, 1);
    alarm_button = 1'b1; tick(); alarm_button = 1'b0;
    repeat (7 * CPS) tick();
    check("alarm_disp", disp, 32'h31313330);
    check("alarm_on", 32'(alarm_sound), 32'd1);
    alarm_button = 1'b1; tick(); alarm_button = 1'b0;
    check("alarm_off", 32'(alarm_sound), 32'd0);
    repeat (CPS) tick();
    check("keeps_counting", disp, 32'h31313331);
    press(2, 3, 1); press(3, 3, 1);
    repeat (KTO * CPS + 2) tick();
    check("timeout_disp", disp, asc(bcd(m_now)));
    press(5, 3, 0);
    check("fresh_buffer", disp, 32'h30303035);
    key = 4'd10; tick();
    press(2, 3, 1); press(3, 3, 1); press(5, 3, 1); press(9, 3, 1);
    time_button = 1'b1; tick(); time_button = 1'b0;
    repeat (3) tick();
    check("load_2359", disp, 32'h32333539);
    repeat (CPS) tick();
    check("day_wrap", disp, 32'h30303030);
    key = 4'd7;
    repeat (20) tick();
    check("hold_one_digit", disp, 32'h30303037);
    key = 4'd10; tick();
    repeat (4) press(9, 2, 1);
    time_button = 1'b1; tick(); time_button = 1'b0;
    repeat (3) tick();
    check("clamp", disp, 32'h32333539);
    for (int it = 0; it < 300; it++) begin
      stopwatch = $urandom_range(0, 4) != 0;
      if (it == 150) begin
        #2 reset = 1'b0;
        #1 model_reset();
        check("async_rst_disp", disp, 32'h30303030);
        check("async_rst_snd", 32'(alarm_sound), 32'd0);
        tick(); tick();
        reset = 1'b1;
      end
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          press($urandom_range(0, 9), $urandom_range(1, 4), 0);
          key = 4'($urandom_range(10, 15));
          repeat ($urandom_range(1, 3)) tick();
        end
        3: begin
          time_button  = 1'b1;
          alarm_button = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 2)) tick();
          time_button  = 1'b0;
          alarm_button = 1'b0;
          tick();
        end
        4: begin
          alarm_button = 1'b1;
          repeat ($urandom_range(1, 3)) tick();
          alarm_button = 1'b0;
          tick();
        end
        default: repeat ($urandom_range(1, 200)) tick();
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_clock.md
Name: alarm_clock

Overview:
- 24-hour digital alarm clock core, the top of the alarm-clock subsystem.
- Contains a keypad digit entry buffer, a 1-second/1-minute timebase, the current-time counter, the alarm-time register, display selection, and alarm comparison.
- Drives four ASCII display digits (HH:MM) and an alarm sound output.

Parameters:
- CLKS_PER_SEC, 256, clock cycles per one-second tick.
- KEY_TIMEOUT_SEC, 10, seconds without a key press before partial key entry is abandoned.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately.
- stopwatch  in  1  fast mode: 1 = one clock-minute elapses per one-second tick.
- alarm_button  in  1  level; 1 for at least one cycle loads the buffer into the alarm register, otherwise shows the alarm time.
- time_button  in  1  level; 1 for at least one cycle loads the buffer into the current time.
- key  in  4  keypad code: 0–9 = digit, 10 = no key; 11–15 are treated as no key.
- alarm_sound  out  1  alarm active.
- ms_hour  out  8  ASCII hours tens digit.
- ls_hour  out  8  ASCII hours units digit.
- ms_minute  out  8  ASCII minutes tens digit.
- ls_minute  out  8  ASCII minutes units digit.

Behaviour:
- Reset values:
  - current time 00:00; alarm time 00:00; key buffer 00:00.
  - Timebase counters 0; alarm_sound 0; FSM in SHOW_TIME.
  - All display outputs 8'h30.
- Timebase:
  - Counts clock cycles 0..CLKS_PER_SEC-1 and pulses one_second for 1 cycle on wrap.
  - one_minute pulses every 60 one_second pulses.
  - With stopwatch=1, one_minute = one_second.
- Current time:
  - On one_minute, increments minutes.
  - Minutes 59 -> 00 carries into hours; 23:59 -> 00:00.
  - Digits are held as BCD, one 4-bit digit each.
- Key entry:
  - A digit is accepted on the first cycle key changes from no-key to 0–9.
  - Holding the key adds no further digits; the digit is accepted once per press.
  - An accepted digit shifts the buffer left: ms_hr <= ls_hr <= ms_min <= ls_min <= new digit.
  - Digit values are not range-checked at entry.
  - Example: entering 1,1,2,3 gives 11:23.
- FSM states: SHOW_TIME, KEY_ENTRY, KEY_WAIT_RELEASE, SHOW_ALARM, SET_ALARM, SET_TIME.
  - SHOW_TIME, on accepted digit -> KEY_WAIT_RELEASE.
  - SHOW_TIME, on alarm_button -> SHOW_ALARM.
  - KEY_WAIT_RELEASE -> KEY_ENTRY when key returns to no-key.
  - KEY_ENTRY, on the next digit -> KEY_WAIT_RELEASE.
  - KEY_ENTRY, on time_button -> SET_TIME.
  - KEY_ENTRY, on alarm_button -> SET_ALARM.
  - KEY_ENTRY, after KEY_TIMEOUT_SEC one_second pulses with no new digit -> SHOW_TIME, buffer cleared to 00:00.
  - SET_TIME and SET_ALARM load their register from the buffer for exactly one cycle, clear the buffer, then return to SHOW_TIME.
  - SET_TIME also clears the timebase seconds counter.
  - A loaded hours value >23 or minutes value >59 is clamped to 23 or 59.
  - SHOW_ALARM returns to SHOW_TIME when alarm_button is released.
  - If time_button and alarm_button are both high, time_button wins.
- Display:
  - KEY_ENTRY and KEY_WAIT_RELEASE show the buffer.
  - SHOW_ALARM shows the alarm time.
  - All other states show the current time.
  - Each output is {4'h3, digit}.
  - Outputs are registered: one cycle latency after the source changes.
- Alarm:
  - alarm_sound sets on the cycle after current time becomes equal to alarm time following a one_minute increment.
  - It stays set until alarm_button is pressed, or reset.
  - Loading the time via SET_TIME never triggers the alarm.
  - Alarm time 00:00 after reset is a valid alarm.

Optional Feature:
- Macro ALARM_AUTO_OFF_EN.
- Defined: alarm_sound also clears automatically after 60 one_second pulses while set.
- Undefined: alarm_sound stays set until alarm_button or reset.

Test Plan:
- Reset low for 5 cycles -> all displays 8'h30, alarm_sound 0; one_minute does not pulse during reset.
- stopwatch=1; keys 1,1,2,3, each held 3 cycles then 10 for 1 cycle; time_button pulse -> display 11:23 (31,31,32,33).
- Continuing: keys 1,1,3,0 then alarm_button pulse; run 7*256 cycles -> display 11:30, alarm_sound rises the cycle after the 11:30 increment.
- Alarm sounding, then alarm_button pulse -> alarm_sound 0 next cycle; time keeps counting 11:31 after 256 more cycles.
- Enter keys 2,3 then idle 10*256 cycles -> display returns to current time; buffer reads 00:00 on next entry.
- Load 23:59 with stopwatch=1, wait 256 cycles -> 00:00; key held 20 cycles -> exactly one digit shifted.
